// File: rtl/phy_stim_gen.sv
//-----------------------------------------------------------------------------
// phy_stim_gen
//
// Purpose: multi-lane PHY stimulus generator. When it sees start in IDLE it
// latches its configuration and emits num_bursts bursts of burst_len beats,
// separated by gap_len idle cycles. Each lane produces an incrementing,
// decrementing, LFSR or constant word pattern. A beat advances only when
// ready is high, so the outputs hold under backpressure. done pulses for one
// cycle at the end of the sequence.
//
// Configuration macro:
//   PHY_STIM_LFSR_EN - when defined, mode 2 is a per-lane LFSR. When it is
//                      absent, no LFSR logic is built and mode 2 behaves as
//                      the incrementing mode 0.
//
// Parameters:
//   LANES      - number of parallel data lanes (1..8)
//   WIDTH      - bits per lane word (8..32)
//
// Ports:
//   clk_2f     in   single clock; all logic runs on its rising edge
//   reset      in   synchronous, active-high reset
//   start      in   begins a sequence when sampled high in IDLE
//   mode       in   pattern: 0 inc, 1 dec, 2 LFSR, 3 constant
//   burst_len  in   valid beats per burst
//   gap_len    in   idle cycles between bursts
//   num_bursts in   bursts per sequence
//   lane_en    in   per-lane enable mask
//   ready      in   downstream accepts the current beat
//   data_out   out  lane i occupies bits [i*WIDTH +: WIDTH]
//   valid_out  out  per-lane valid
//   busy       out  high from the cycle after start through the DONE cycle
//   done       out  one-cycle pulse at the end of the sequence
//-----------------------------------------------------------------------------
module phy_stim_gen #(
  parameter int LANES = 2,
  parameter int WIDTH = 8
) (
  input  logic                   clk_2f,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [7:0]             burst_len,
  input  logic [7:0]             gap_len,
  input  logic [7:0]             num_bursts,
  input  logic [LANES-1:0]       lane_en,
  input  logic                   ready,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [LANES-1:0]       valid_out,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

  // Constant-mode base word: WIDTH/8 copies of A5 in the low bytes.
  function automatic logic [WIDTH-1:0] const_pat_f();
    logic [WIDTH-1:0] p;
    p = '0;
    for (int b = 0; b < WIDTH / 8; b++) begin
      p[b*8 +: 8] = 8'hA5;
    end
    return p;
  endfunction

  // Per-lane seed for a given pattern mode.
  function automatic logic [WIDTH-1:0] seed_f(input logic [1:0] m, input int lane);
    logic [WIDTH-1:0] idx;
    logic [WIDTH-1:0] s;
    idx = WIDTH'(lane);
    case (m)
      2'd0:    s = idx;
      2'd1:    s = '1 - idx;
`ifdef PHY_STIM_LFSR_EN
      2'd2:    s = idx + ONE_C;
`else
      2'd2:    s = idx;
`endif
      2'd3:    s = const_pat_f() ^ idx;
      default: s = idx;
    endcase
    return s;
  endfunction

  // Advance one lane word by one completed beat.
  function automatic logic [WIDTH-1:0] step_f(input logic [1:0] m, input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] n;
    case (m)
      2'd0:    n = x + ONE_C;
      2'd1:    n = x - ONE_C;
`ifdef PHY_STIM_LFSR_EN
      2'd2:    n = {x[WIDTH-2:0], x[WIDTH-1] ^ x[WIDTH-3] ^ x[WIDTH-4] ^ x[WIDTH-5]};
`else
      2'd2:    n = x + ONE_C;
`endif
      2'd3:    n = x;
      default: n = x;
    endcase
    return n;
  endfunction

  state_t                   state_r;
  logic [1:0]               mode_r;
  logic [7:0]               burst_len_r;
  logic [7:0]               gap_len_r;
  logic [7:0]               num_bursts_r;
  logic [LANES-1:0]         lane_en_r;
  logic [7:0]               beat_cnt_r;
  logic [7:0]               burst_cnt_r;
  logic [7:0]               gap_cnt_r;
  logic [WIDTH-1:0]         lane_r [LANES];
  logic [LANES*WIDTH-1:0]   data_out_r;
  logic [LANES-1:0]         valid_r;
  logic                     busy_r;
  logic                     done_r;

  logic [1:0]               mode_eff_s;
  logic [WIDTH-1:0]         seed_s [LANES];
  logic [WIDTH-1:0]         step_s [LANES];
  logic [LANES*WIDTH-1:0]   seed_pack_s;
  logic [LANES*WIDTH-1:0]   step_pack_s;

  // Mode as it will be latched: without the LFSR build, mode 2 collapses to 0.
  always_comb begin
    mode_eff_s = mode;
`ifndef PHY_STIM_LFSR_EN
    if (mode == 2'd2) begin
      mode_eff_s = 2'd0;
    end else begin
      mode_eff_s = mode;
    end
`endif
  end

  // Seed and next-beat lane words, plus their masked output packings.
  always_comb begin
    seed_pack_s = '0;
    step_pack_s = '0;
    for (int i = 0; i < LANES; i++) begin
      seed_s[i] = seed_f(mode_eff_s, i);
      step_s[i] = step_f(mode_r, lane_r[i]);
      seed_pack_s[i*WIDTH +: WIDTH] = lane_en[i]   ? seed_s[i] : '0;
      step_pack_s[i*WIDTH +: WIDTH] = lane_en_r[i] ? step_s[i] : '0;
    end
  end

  // Sequencer FSM with all outputs and lane state registered.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_r      <= IDLE;
      mode_r       <= 2'd0;
      burst_len_r  <= 8'd0;
      gap_len_r    <= 8'd0;
      num_bursts_r <= 8'd0;
      lane_en_r    <= '0;
      beat_cnt_r   <= 8'd0;
      burst_cnt_r  <= 8'd0;
      gap_cnt_r    <= 8'd0;
      for (int i = 0; i < LANES; i++) begin
        lane_r[i] <= '0;
      end
      data_out_r   <= '0;
      valid_r      <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r  <= 1'b0;
          valid_r <= '0;
          busy_r  <= 1'b0;
          if (start) begin
            mode_r       <= mode_eff_s;
            burst_len_r  <= burst_len;
            gap_len_r    <= gap_len;
            num_bursts_r <= num_bursts;
            lane_en_r    <= lane_en;
            beat_cnt_r   <= 8'd0;
            burst_cnt_r  <= 8'd0;
            gap_cnt_r    <= 8'd0;
            for (int i = 0; i < LANES; i++) begin
              lane_r[i] <= seed_s[i];
            end
            data_out_r   <= seed_pack_s;
            busy_r       <= 1'b1;
            // Empty sequences go straight to DONE without any beat.
            if ((num_bursts == 8'd0) || (burst_len == 8'd0)) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= BURST;
              valid_r <= lane_en;
            end
          end
        end

        BURST: begin
          // The beat on offer completes only when downstream takes it.
          if (ready) begin
            for (int i = 0; i < LANES; i++) begin
              lane_r[i] <= step_s[i];
            end
            data_out_r <= step_pack_s;
            if (beat_cnt_r == (burst_len_r - 8'd1)) begin
              beat_cnt_r <= 8'd0;
              if (burst_cnt_r == (num_bursts_r - 8'd1)) begin
                state_r <= DONE;
                done_r  <= 1'b1;
                valid_r <= '0;
              end else begin
                burst_cnt_r <= burst_cnt_r + 8'd1;
                // A zero gap keeps BURST and valid asserted: back-to-back beats.
                if (gap_len_r != 8'd0) begin
                  state_r   <= GAP;
                  gap_cnt_r <= gap_len_r;
                  valid_r   <= '0;
                end
              end
            end else begin
              beat_cnt_r <= beat_cnt_r + 8'd1;
            end
          end
        end

        GAP: begin
          if (gap_cnt_r == 8'd1) begin
            state_r   <= BURST;
            valid_r   <= lane_en_r;
            gap_cnt_r <= 8'd0;
          end else begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
          end
        end

        DONE: begin
          // start is deliberately not examined here.
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          valid_r <= '0;
        end

        default: begin
          state_r <= IDLE;
          valid_r <= '0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_out_r;
  assign valid_out = valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_phy_stim_gen.sv
module tb_phy_stim_gen;
  localparam int LANES = 2;
  localparam int WIDTH = 8;

  logic                   clk_2f = 1'b0;
  logic                   reset;
  logic                   start;
  logic [1:0]             mode;
  logic [7:0]             burst_len;
  logic [7:0]             gap_len;
  logic [7:0]             num_bursts;
  logic [LANES-1:0]       lane_en;
  logic                   ready;
  logic [LANES*WIDTH-1:0] data_out;
  logic [LANES-1:0]       valid_out;
  logic                   busy;
  logic                   done;

  int checks = 0;
  int errors = 0;

  always #5 clk_2f = ~clk_2f;

  phy_stim_gen #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .burst_len  (burst_len),
    .gap_len    (gap_len),
    .num_bursts (num_bursts),
    .lane_en    (lane_en),
    .ready      (ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value of lane i after k completed beats, straight from the pattern rules.
  function automatic logic [WIDTH-1:0] exp_lane(input logic [1:0] m, input int i, input int k);
    int unsigned x;
    int unsigned par;
    int unsigned msk;
    int unsigned cpat;
    logic [1:0]  me;
    msk = (32'd1 << WIDTH) - 32'd1;
    me  = m;
`ifndef PHY_STIM_LFSR_EN
    if (m == 2'd2) me = 2'd0;
`endif
    cpat = 0;
    for (int b = 0; b < WIDTH / 8; b++) cpat = cpat | (32'hA5 << (8 * b));
    case (me)
      2'd0: x = (i + k) & msk;
      2'd1: x = (msk - i - k) & msk;
      2'd2: begin
        x = i + 1;
        for (int s = 0; s < k; s++) begin
          par = ((x >> (WIDTH-1)) ^ (x >> (WIDTH-3)) ^ (x >> (WIDTH-4)) ^ (x >> (WIDTH-5))) & 32'd1;
          x = ((x << 1) | par) & msk;
        end
      end
      default: x = cpat ^ i;
    endcase
    return x[WIDTH-1:0];
  endfunction

  // Run one sequence from a negedge; observes every cycle until done.
  task automatic run_seq(input logic [1:0] m, input logic [7:0] bl, input logic [7:0] gl,
                         input logic [7:0] nb, input logic [LANES-1:0] en,
                         input bit rnd_ready, input logic [63:0] lo_mask, input string tag);
    int  k = 0;
    int  cyc = 0;
    int  idle_run = 0;
    int  total;
    bit  was_valid = 0;
    bit  prev_beat = 0;
    bit  seen_done = 0;
    total = int'(bl) * int'(nb);
    mode = m; burst_len = bl; gap_len = gl; num_bursts = nb; lane_en = en;
    start = 1'b1; ready = 1'b1;
    while (!seen_done && cyc < 3000) begin
      @(negedge clk_2f);
      // Scramble config and poke start while busy: both must be ignored.
      start = 1'($urandom_range(0, 1));
      mode = 2'($urandom); burst_len = 8'($urandom); gap_len = 8'($urandom);
      num_bursts = 8'($urandom); lane_en = LANES'($urandom);
      chk({tag, "/busy"}, busy, 1);
      if (cyc == 0 && total > 0) chk({tag, "/first_valid"}, valid_out, en);
      chk({tag, "/valid_shape"}, (valid_out == '0) || (valid_out == en), 1);
      for (int i = 0; i < LANES; i++)
        if (!en[i]) chk({tag, "/disabled_zero"}, data_out[i*WIDTH +: WIDTH], 0);
      if (done) begin
        seen_done = 1;
        chk({tag, "/beat_total"}, k, total);
        chk({tag, "/done_valid"}, valid_out, 0);
        if (total > 0) chk({tag, "/done_after_last"}, prev_beat, 1);
        else           chk({tag, "/zero_len_cycles"}, cyc, 0);
        start = 1'b1;  // start in the DONE cycle must not be taken
      end else if (valid_out != '0) begin
        if (!was_valid && k > 0 && bl != 8'd0) begin
          chk({tag, "/gap_len"}, idle_run, gl);
          chk({tag, "/burst_edge"}, k % int'(bl), 0);
        end
        for (int i = 0; i < LANES; i++)
          if (en[i]) chk({tag, "/lane_data"}, data_out[i*WIDTH +: WIDTH], exp_lane(m, i, k));
        if (rnd_ready) ready = ($urandom_range(0, 9) < 7);
        else           ready = !(cyc < 64 && lo_mask[cyc]);
        prev_beat = ready;
        if (ready) k++;
        was_valid = 1;
        idle_run = 0;
      end else begin
        was_valid = 0;
        idle_run++;
        prev_beat = 0;
        ready = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    chk({tag, "/timeout"}, seen_done, 1);
    @(negedge clk_2f);
    chk({tag, "/idle_busy"}, busy, 0);
    chk({tag, "/idle_done"}, done, 0);
    chk({tag, "/idle_valid"}, valid_out, 0);
    start = 1'b0;
    ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; burst_len = 8'd0; gap_len = 8'd0;
    num_bursts = 8'd0; lane_en = '0; ready = 1'b1;
    repeat (3) @(negedge clk_2f);
    chk("reset/data", data_out, 0);
    chk("reset/valid", valid_out, 0);
    chk("reset/busy", busy, 0);
    chk("reset/done", done, 0);
    // First start coincides with reset release.
    reset = 1'b0;
    run_seq(2'd0, 8'd4, 8'd2, 8'd2, 2'b11, 0, 64'h0, "inc");
    run_seq(2'd0, 8'd4, 8'd0, 8'd1, 2'b11, 0, 64'h0E, "backpressure");
    run_seq(2'd1, 8'd3, 8'd0, 8'd1, 2'b10, 0, 64'h0, "dec");
    run_seq(2'd0, 8'd4, 8'd2, 8'd0, 2'b11, 0, 64'h0, "zero_nb");
    run_seq(2'd1, 8'd0, 8'd1, 8'd3, 2'b01, 0, 64'h0, "zero_bl");

    // Reset on the 2nd beat, then a fresh start must reseed.
    mode = 2'd0; burst_len = 8'd4; gap_len = 8'd2; num_bursts = 8'd2; lane_en = 2'b11;
    start = 1'b1; ready = 1'b1;
    @(negedge clk_2f);
    start = 1'b0;
    @(negedge clk_2f);
    chk("rst_mid/second_beat", data_out[WIDTH-1:0], 8'h01);
    reset = 1'b1;
    @(negedge clk_2f);
    chk("rst_mid/data", data_out, 0);
    chk("rst_mid/valid", valid_out, 0);
    chk("rst_mid/busy", busy, 0);
    chk("rst_mid/done", done, 0);
    reset = 1'b0;
    run_seq(2'd0, 8'd3, 8'd1, 8'd1, 2'b01, 0, 64'h0, "reseed");

    run_seq(2'd2, 8'd5, 8'd1, 8'd1, 2'b11, 0, 64'h0, "lfsr");
    run_seq(2'd3, 8'd3, 8'd1, 8'd2, 2'b01, 1, 64'h0, "const");
    run_seq(2'd0, 8'd130, 8'd1, 8'd2, 2'b11, 1, 64'h0, "inc_wrap");
    run_seq(2'd1, 8'd130, 8'd0, 8'd2, 2'b11, 1, 64'h0, "dec_wrap");

    for (int r = 0; r < 8; r++) begin
      run_seq(2'($urandom), 8'($urandom_range(1, 6)), 8'($urandom_range(0, 3)),
              8'($urandom_range(0, 3)), LANES'($urandom_range(1, 3)), 1, 64'h0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
